// File: rtl/mult_pipe_pkg.sv
// mult_pipe_pkg: shared types and helpers for the pipelined multiply unit.
//   - ALU_FUNC          : execute-stage function encoding. Only the four MUL*
//                         codes are legal for the multiplier.
//   - MULT_STAGE_PACKET : per-stage pipeline contents (valid, accumulator,
//                         shifted multiplicand, remaining multiplier bits,
//                         func, tag, ROB index).
//   - operand-extension and result-select helper functions.
// The MULT_* localparams fix the widths of the stage packet. The parameters
// of mult_pipe default to these values and must be left at them.
package mult_pipe_pkg;

    localparam int MULT_XLEN      = 32;
    localparam int MULT_PW        = 2 * MULT_XLEN;
    localparam int MULT_TAG_W     = 6;
    localparam int MULT_ROB_IDX_W = 5;

    // Returned for a non-multiply func so that misuse is easy to spot.
    localparam logic [MULT_XLEN-1:0] MULT_ILLEGAL_RESULT = 32'hfacebeec;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLT    = 5'd2,
        ALU_SLTU   = 5'd3,
        ALU_AND    = 5'd4,
        ALU_OR     = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13
    } ALU_FUNC;

    typedef struct packed {
        logic                      valid;
        logic [MULT_PW-1:0]        acc;
        logic [MULT_PW-1:0]        a;
        logic [MULT_PW-1:0]        b;
        ALU_FUNC                   func;
        logic [MULT_TAG_W-1:0]     tag;
        logic [MULT_ROB_IDX_W-1:0] rob_idx;
    } MULT_STAGE_PACKET;

    // rs1 is treated as signed for MUL, MULH and MULHSU.
    function automatic logic opa_is_signed(input ALU_FUNC func);
        case (func)
            ALU_MUL, ALU_MULH, ALU_MULHSU: opa_is_signed = 1'b1;
            default:                       opa_is_signed = 1'b0;
        endcase
    endfunction

    // rs2 is treated as signed for MUL and MULH only.
    function automatic logic opb_is_signed(input ALU_FUNC func);
        case (func)
            ALU_MUL, ALU_MULH: opb_is_signed = 1'b1;
            default:           opb_is_signed = 1'b0;
        endcase
    endfunction

    function automatic logic [MULT_PW-1:0] extend_operand(
        input logic [MULT_XLEN-1:0] op,
        input logic                 sgn
    );
        if (sgn) begin
            extend_operand = {{MULT_XLEN{op[MULT_XLEN-1]}}, op};
        end else begin
            extend_operand = {{MULT_XLEN{1'b0}}, op};
        end
    endfunction

    function automatic logic [MULT_XLEN-1:0] select_result(
        input ALU_FUNC            func,
        input logic [MULT_PW-1:0] acc
    );
        case (func)
            ALU_MUL:                        select_result = acc[MULT_XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: select_result = acc[MULT_PW-1:MULT_XLEN];
            default:                        select_result = MULT_ILLEGAL_RESULT;
        endcase
    endfunction

endpackage

// File: rtl/mult_pipe_if.sv
// mult_pipe_if: issue / complete bus of the pipelined multiply unit.
//   Issue side   : in_valid, in_ready, in_opa, in_opb, in_func, in_tag,
//                  in_rob_idx, squash
//   Complete side: out_valid, out_ready, out_result, out_tag, out_rob_idx
//   Status       : busy
// Modports: master = issuing / consuming side, slave = the multiply unit.
interface mult_pipe_if
    import mult_pipe_pkg::*;
#(
    parameter int XLEN      = MULT_XLEN,
    parameter int TAG_W     = MULT_TAG_W,
    parameter int ROB_IDX_W = MULT_ROB_IDX_W
);
    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      in_opa;
    logic [XLEN-1:0]      in_opb;
    ALU_FUNC              in_func;
    logic [TAG_W-1:0]     in_tag;
    logic [ROB_IDX_W-1:0] in_rob_idx;
    logic                 squash;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_result;
    logic [TAG_W-1:0]     out_tag;
    logic [ROB_IDX_W-1:0] out_rob_idx;
    logic                 busy;

    modport master (
        output in_valid, in_opa, in_opb, in_func, in_tag, in_rob_idx, squash, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_rob_idx, busy
    );

    modport slave (
        input  in_valid, in_opa, in_opb, in_func, in_tag, in_rob_idx, squash, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_rob_idx, busy
    );
endinterface

// File: rtl/mult_stage.sv
// mult_stage: combinational slice of the multiplier pipeline.
//   in_pkt  : packet leaving the previous stage register (or the issue port)
//   out_pkt : packet to be captured by this stage's register
// Adds a * (lowest CHUNK_W bits of b) into the accumulator. The multiplicand
// is then shifted left and the multiplier right by CHUNK_W, so every stage
// always works on the low chunk and the positional weight comes from a.
module mult_stage
    import mult_pipe_pkg::*;
#(
    parameter int CHUNK_W = MULT_PW / 4
) (
    input  MULT_STAGE_PACKET in_pkt,
    output MULT_STAGE_PACKET out_pkt
);
    localparam logic [MULT_PW-1:0] CHUNK_MASK = {MULT_PW{1'b1}} >> (MULT_PW - CHUNK_W);

    logic [MULT_PW-1:0] chunk_s;

    // Partial product of one chunk, accumulate, and shift operands along.
    always_comb begin
        chunk_s     = in_pkt.b & CHUNK_MASK;
        out_pkt     = in_pkt;
        out_pkt.acc = in_pkt.acc + (in_pkt.a * chunk_s);
        out_pkt.a   = in_pkt.a << CHUNK_W;
        out_pkt.b   = in_pkt.b >> CHUNK_W;
    end
endmodule

// File: rtl/mult_pipe.sv
// mult_pipe: pipelined integer multiply unit (MUL/MULH/MULHSU/MULHU).
//   clock       : system clock
//   reset       : asynchronous, active-high reset
//   io (slave)  : issue handshake (in_*), squash, complete handshake (out_*),
//                 busy
//   perf_issued / perf_completed / perf_stall : 32-bit event counters,
//                 present only when MULT_PERF_CNT_EN is defined
// One op is accepted per cycle; a result appears NUM_STAGES cycles after
// acceptance when the output is not back-pressured. Stall propagates
// backwards so that a stage only moves when the one ahead of it is empty or
// moving. squash clears every valid bit at the next edge.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int XLEN       = MULT_XLEN,
    parameter int NUM_STAGES = 4,
    parameter int TAG_W      = MULT_TAG_W,
    parameter int ROB_IDX_W  = MULT_ROB_IDX_W
) (
    input  logic        clock,
    input  logic        reset,
    mult_pipe_if.slave  io
`ifdef MULT_PERF_CNT_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_completed,
    output logic [31:0] perf_stall
`endif
);
    localparam int CHUNK_W = MULT_PW / NUM_STAGES;
    localparam int LAST    = NUM_STAGES - 1;

    MULT_STAGE_PACKET      issue_pkt_s;
    MULT_STAGE_PACKET      stage_in_s  [NUM_STAGES];
    MULT_STAGE_PACKET      stage_out_s [NUM_STAGES];
    MULT_STAGE_PACKET      stage_d     [NUM_STAGES];
    MULT_STAGE_PACKET      stage_q     [NUM_STAGES];
    logic [NUM_STAGES-1:0] valid_s;
    logic [NUM_STAGES-1:0] adv_s;

    // Build the entry packet: extended operands and an empty accumulator.
    always_comb begin
        issue_pkt_s         = '0;
        issue_pkt_s.valid   = io.in_valid;
        issue_pkt_s.acc     = {MULT_PW{1'b0}};
        issue_pkt_s.a       = extend_operand(io.in_opa, opa_is_signed(io.in_func));
        issue_pkt_s.b       = extend_operand(io.in_opb, opb_is_signed(io.in_func));
        issue_pkt_s.func    = io.in_func;
        issue_pkt_s.tag     = io.in_tag;
        issue_pkt_s.rob_idx = io.in_rob_idx;
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_in_s[k] = issue_pkt_s;
        end else begin : g_rest
            assign stage_in_s[k] = stage_q[k-1];
        end

        mult_stage #(
            .CHUNK_W (CHUNK_W)
        ) u_stage (
            .in_pkt  (stage_in_s[k]),
            .out_pkt (stage_out_s[k])
        );
    end

    // Gather the stage valid bits into one vector.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            valid_s[k] = stage_q[k].valid;
        end
    end

    // Stage k may advance when the output is being taken or when any stage
    // at or after k holds a bubble that the pipe can close up into.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            adv_s[k] = io.out_ready | (|(~valid_s >> k));
        end
    end

    // Next-state for every stage register: squash, advance, or hold.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_d[k] = stage_q[k];
            if (io.squash) begin
                stage_d[k].valid = 1'b0;
            end else if (adv_s[k]) begin
                stage_d[k] = stage_out_s[k];
            end else begin
                stage_d[k] = stage_q[k];
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign io.in_ready    = adv_s[0];
    assign io.out_valid   = stage_q[LAST].valid;
    assign io.out_result  = XLEN'(select_result(stage_q[LAST].func, stage_q[LAST].acc));
    assign io.out_tag     = TAG_W'(stage_q[LAST].tag);
    assign io.out_rob_idx = ROB_IDX_W'(stage_q[LAST].rob_idx);
    assign io.busy        = |valid_s;

    // The final stage's operand copies have been fully consumed.
    logic unused_last_s;
    assign unused_last_s = ^{stage_q[LAST].a, stage_q[LAST].b};

`ifdef MULT_PERF_CNT_EN
    logic        accept_s;
    logic        complete_s;
    logic        stall_s;
    logic [31:0] perf_issued_q,    perf_issued_d;
    logic [31:0] perf_completed_q, perf_completed_d;
    logic [31:0] perf_stall_q,     perf_stall_d;

    // An issue or completion in a squash cycle is discarded, so not counted.
    assign accept_s   = io.in_valid & adv_s[0] & ~io.squash;
    assign complete_s = stall_q_free_complete();
    assign stall_s    = stage_q[LAST].valid & ~io.out_ready;

    function automatic logic stall_q_free_complete();
        stall_q_free_complete = stage_q[LAST].valid & io.out_ready & ~io.squash;
    endfunction

    // Counter increments; the counters wrap modulo 2^32.
    always_comb begin
        perf_issued_d    = perf_issued_q;
        perf_completed_d = perf_completed_q;
        perf_stall_d     = perf_stall_q;
        if (accept_s) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end else begin
            perf_issued_d = perf_issued_q;
        end
        if (complete_s) begin
            perf_completed_d = perf_completed_q + 32'd1;
        end else begin
            perf_completed_d = perf_completed_q;
        end
        if (stall_s) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Counter registers, cleared by reset only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_issued_q    <= 32'd0;
            perf_completed_q <= 32'd0;
            perf_stall_q     <= 32'd0;
        end else begin
            perf_issued_q    <= perf_issued_d;
            perf_completed_q <= perf_completed_d;
            perf_stall_q     <= perf_stall_d;
        end
    end

    assign perf_issued    = perf_issued_q;
    assign perf_completed = perf_completed_q;
    assign perf_stall     = perf_stall_q;
`endif

endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
Parametrised, pipelined integer multiply unit for the execute stage; replaces the single-cycle combinational multiplier. Accepts one MUL/MULH/MULHSU/MULHU operation per cycle under valid/ready handshake. Carries destination tag and ROB index alongside the data. Supports back-pressure from complete/CDB arbitration and a whole-pipe squash on branch mispredict.

Parameters:
XLEN, 32, operand/result width
NUM_STAGES, 4, pipeline depth; must divide 2*XLEN (legal: 1,2,4,8,16,...)
TAG_W, 6, physical destination tag width
ROB_IDX_W, 5, ROB index width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  issue request
in_ready  out  1  unit can accept this cycle
in_opa  in  XLEN  rs1 operand
in_opb  in  XLEN  rs2 operand
in_func  in  ALU_FUNC  ALU_MUL/ALU_MULH/ALU_MULHSU/ALU_MULHU
in_tag  in  TAG_W  destination physical tag
in_rob_idx  in  ROB_IDX_W  ROB entry
squash  in  1  flush all in-flight ops
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  XLEN  selected product half
out_tag  out  TAG_W  tag of out_result
out_rob_idx  out  ROB_IDX_W  ROB entry of out_result
busy  out  1  any stage valid

Behaviour:
- Reset (async, on posedge reset): all stage valid bits 0; out_valid=0, busy=0, in_ready=1; data/tag/rob_idx registers 0.
- Operand prep on accept: opa sign-extended to 2*XLEN if func in {MULH, MULHSU, MUL}, else zero-extended; opb sign-extended if func in {MULH, MUL}, else zero-extended. Product = low 2*XLEN bits of ext_a*ext_b.
- Stage k (0..NUM_STAGES-1) adds ext_a * chunk_k(ext_b) << (k*C) into a 2*XLEN accumulator, with C = 2*XLEN/NUM_STAGES. Each stage register holds: valid, accumulator, ext_a, remaining ext_b, func, tag, rob_idx.
- Result select from final accumulator: MUL -> [XLEN-1:0]; others -> [2*XLEN-1:XLEN]. Non-mult func is illegal input; result = XLEN'hfacebeec.
- Latency: accept in cycle N -> out_valid in cycle N+NUM_STAGES when unstalled. Throughput 1/cycle.
- Stall: last stage holds while out_valid && !out_ready. Stage k advances iff stage k+1 empty or advancing (ripple). in_ready = !stage0.valid || stage0 advancing (combinational from out_ready).
- Handshake: transfer occurs when valid && ready. Outputs are stable while out_valid && !out_ready.
- Squash: synchronous. All valid bits clear at the next edge. An in_valid presented in the squash cycle is dropped. An out handshake in the squash cycle does not count. in_ready stays as computed (an issue in that cycle is simply discarded).
- Simultaneous full pipe + out_ready=1 + in_valid=1: all advance, new op accepted, no bubble.
- NUM_STAGES=1: behaves as a registered single-cycle multiplier.
- busy = OR of all stage valid bits.

Optional Feature:
MULT_PERF_CNT_EN
- Defined: adds outputs perf_issued[31:0], perf_completed[31:0], perf_stall[31:0]. These count accepted ops, output handshakes, and cycles with out_valid && !out_ready. All three are cleared by reset only (not by squash) and wrap modulo 2^32.
- Undefined: ports and counters absent; all other behaviour unchanged.

Decomposition:
- Shared package (sys_defs): ALU_FUNC enum (existing), MULT_STAGE_PACKET struct (valid, acc, a, b, func, tag, rob_idx).
- One sub-module: mult_stage. It is purely combinational (one chunk partial product plus accumulate). It is instantiated NUM_STAGES times in a generate loop; registers and stall logic stay in mult_pipe.

Test Plan:
- MUL 7 * -3 (opb=32'hFFFFFFFD), out_ready=1 -> out_result=32'hFFFFFFEB exactly 4 cycles later, with tag/rob_idx echoed.
- MULH/MULHSU/MULHU with opa=opb=32'h80000000 -> 32'h40000000 / 32'hC0000000 / 32'h40000000.
- Back-to-back 6 ops with out_ready=0 from cycle 2 -> pipe fills, in_ready drops after 4 accepts. Raise out_ready -> all 6 results in issue order, none lost or duplicated.
- 3 ops in flight, squash=1 for one cycle alongside a new in_valid -> out_valid never asserts for any of the 4; busy=0 next cycle.
- Reset asserted asynchronously mid-stream (between edges) -> out_valid/busy drop immediately, in_ready=1; post-reset op completes normally.
- MULT_PERF_CNT_EN defined, run the stall scenario -> perf_issued=6, perf_completed=6, perf_stall equals the cycles out_valid was held.
